rtc_time_writer: RTL and testbench

Writes an edited time of day back to the external multiplexed-bus RTC. It sits beside the per-field BCD edit counters for hour, minute and second. When the user commits an edit, the block takes a snapshot of the three BCD values and checks them. If they are valid, it runs a sequence of byte writes on the RTC address/data bus and reports completion. Reads from the RTC remain the job of the existing read path; this block only drives write cycles.

---
 rtl/rtc_time_writer_if.sv | 20 ++
 rtl/rtc_time_writer.sv | 126 ++++++++++++
 tb/tb_rtc_time_writer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rtc_time_writer_if.sv
// rtc_time_writer_if: commit request, BCD time inputs and RTC multiplexed-bus outputs
interface rtc_time_writer_if;
   logic       start;
   logic [7:0] hour_bcd;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       busy;
   logic       done;
   logic       err;
   logic       rtc_cs_n;
   logic       rtc_as;
   logic       rtc_wr_n;
   logic       rtc_rd_n;
   logic [7:0] rtc_ad_out;
   logic       rtc_ad_oe;
   modport master (output start, hour_bcd, min_bcd, sec_bcd,
                   input busy, done, err, rtc_cs_n, rtc_as, rtc_wr_n, rtc_rd_n, rtc_ad_out, rtc_ad_oe);
   modport slave (input start, hour_bcd, min_bcd, sec_bcd,
                  output busy, done, err, rtc_cs_n, rtc_as, rtc_wr_n, rtc_rd_n, rtc_ad_out, rtc_ad_oe);
endinterface

// File: rtl/rtc_time_writer.sv
// rtc_time_writer: validates a BCD time snapshot and writes sec/min/hour to the RTC bus.
// Define RTC_XFER_CMD_EN to append a CMD_XFER write to ADDR_CMD after the hour write.
module rtc_time_writer #(
   parameter int         PHASE_CYC = 4,
   parameter logic [7:0] ADDR_SEC  = 8'h21,
   parameter logic [7:0] ADDR_MIN  = 8'h22,
   parameter logic [7:0] ADDR_HOUR = 8'h23,
   parameter logic [7:0] ADDR_CMD  = 8'hF0,
   parameter logic [7:0] CMD_XFER  = 8'hF2
) (
   input logic               clk,
   input logic               reset,
   rtc_time_writer_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, ADDR, LATCH, DATA, HOLD, GAP} state_t;
`ifdef RTC_XFER_CMD_EN
   localparam logic [1:0] LAST = 2'd3;
`else
   localparam logic [1:0] LAST = 2'd2;
`endif
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] idx_q, idx_d;
   logic       chk_q, chk_d;
   logic [7:0] hour_q, min_q, sec_q;
   logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic       cs_n_q, cs_n_d, as_q, as_d, wr_n_q, wr_n_d, oe_q, oe_d;
   logic [7:0] ad_q, ad_d;
   logic       ok, phase_end, take;
   logic [7:0] addr_sel, data_sel;
   assign ok = (sec_q[7:4] <= 4'd5) && (sec_q[3:0] <= 4'd9)
            && (min_q[7:4] <= 4'd5) && (min_q[3:0] <= 4'd9)
            && ((hour_q[7:4] == 4'd0) ? (hour_q[3:0] != 4'd0 && hour_q[3:0] <= 4'd9)
                                      : (hour_q[7:4] == 4'd1 && hour_q[3:0] <= 4'd2));
   assign phase_end = cnt_q == 8'(PHASE_CYC - 1);
   assign take = state_q == IDLE && !chk_q && bus.start;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      chk_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (state_q == IDLE) begin
         chk_d = take;
         if (chk_q && ok) begin
            state_d = ADDR;
            cnt_d   = 8'd0;
            idx_d   = 2'd0;
         end
         err_d = chk_q && !ok;
      end else if (!phase_end) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = 8'd0;
         case (state_q)
            ADDR:    state_d = LATCH;
            LATCH:   state_d = DATA;
            DATA:    state_d = HOLD;
            HOLD:    state_d = GAP;
            default: begin
               state_d = (idx_q == LAST) ? IDLE : ADDR;
               done_d  = idx_q == LAST;
               idx_d   = (idx_q == LAST) ? idx_q : idx_q + 2'd1;
            end
         endcase
      end
   end
   // Bus outputs are decoded from the next state so the registers line up with the phase.
   always_comb begin
      addr_sel = (idx_d == 2'd0) ? ADDR_SEC : (idx_d == 2'd1) ? ADDR_MIN
               : (idx_d == 2'd2) ? ADDR_HOUR : ADDR_CMD;
      data_sel = (idx_d == 2'd0) ? sec_q : (idx_d == 2'd1) ? min_q
               : (idx_d == 2'd2) ? hour_q : CMD_XFER;
      busy_d = state_d != IDLE;
      oe_d   = state_d inside {ADDR, LATCH, DATA, HOLD};
      cs_n_d = !oe_d;
      as_d   = state_d == ADDR;
      wr_n_d = state_d != DATA;
      ad_d   = (state_d inside {ADDR, LATCH}) ? addr_sel
             : (state_d inside {DATA, HOLD}) ? data_sel : 8'h00;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= 2'd0;
         chk_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         as_q    <= 1'b0;
         wr_n_q  <= 1'b1;
         oe_q    <= 1'b0;
         ad_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         chk_q   <= chk_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cs_n_q  <= cs_n_d;
         as_q    <= as_d;
         wr_n_q  <= wr_n_d;
         oe_q    <= oe_d;
         ad_q    <= ad_d;
      end
      if (!reset && take) begin
         hour_q <= bus.hour_bcd;
         min_q  <= bus.min_bcd;
         sec_q  <= bus.sec_bcd;
      end
   end
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.rtc_cs_n   = cs_n_q;
   assign bus.rtc_as     = as_q;
   assign bus.rtc_wr_n   = wr_n_q;
   assign bus.rtc_rd_n   = 1'b1;
   assign bus.rtc_ad_out = ad_q;
   assign bus.rtc_ad_oe  = oe_q;
endmodule

// File: tb/tb_rtc_time_writer.sv
// tb_rtc_time_writer: scoreboard bench with PHASE_CYC=4 and PHASE_CYC=1 instances.
module tb_rtc_time_writer;
`ifdef RTC_XFER_CMD_EN
   localparam int NW = 4;
`else
   localparam int NW = 3;
`endif
   localparam logic [15:0] RSTV = 16'b0001_0110_0000_0000;
   typedef struct packed {logic [7:0] a; logic [7:0] d;} pair_t;
   logic clk = 1'b0;
   logic reset;
   int   total = 0, passed = 0;
   logic rd_bad = 1'b0;
   pair_t expq[2][$];
   int    lenq[2][$];
   int    errq[$];
   int    blen[2];
   logic  p_as[2], p_wr[2];
   logic [7:0] la[2];
   rtc_time_writer_if a ();
   rtc_time_writer_if b ();
   rtc_time_writer #(.PHASE_CYC(4)) dut4 (.clk(clk), .reset(reset), .bus(a));
   rtc_time_writer #(.PHASE_CYC(1)) dut1 (.clk(clk), .reset(reset), .bus(b));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic fail(input string name);
      total++;
      $display("FAIL %s: got event expected none", name);
   endtask
   task automatic mon(input int i, input logic as_, input logic wr_n, input logic cs_n, input logic busy,
                      input logic done, input logic err, input logic rd_n, input logic [7:0] ad);
      pair_t e;
      int    l;
      if (rd_n !== 1'b1) rd_bad = 1'b1;
      if (reset) begin
         blen[i] = 0;
         p_as[i] = 1'b0;
         p_wr[i] = 1'b1;
      end else begin
         if (busy) blen[i]++;
         if (p_as[i] && !as_) la[i] = ad;
         if (p_wr[i] && !wr_n) begin
            if (expq[i].size() == 0) fail("extra_write");
            else begin
               e = expq[i].pop_front();
               chk("write_pair", {16'h0, la[i], ad}, {16'h0, e.a, e.d});
            end
         end
         if (done) begin
            if (lenq[i].size() == 0) fail("extra_done");
            else begin
               l = lenq[i].pop_front();
               chk("busy_len", blen[i], l);
               chk("done_busy_low", {31'h0, busy}, 0);
            end
            blen[i] = 0;
         end
         if (err) begin
            if (i != 0 || errq.size() == 0) fail("extra_err");
            else begin
               void'(errq.pop_front());
               chk("err_idle", {30'h0, busy, cs_n}, 32'd1);
            end
         end
         p_as[i] = as_;
         p_wr[i] = wr_n;
      end
   endtask
   always @(negedge clk) begin
      mon(0, a.rtc_as, a.rtc_wr_n, a.rtc_cs_n, a.busy, a.done, a.err, a.rtc_rd_n, a.rtc_ad_out);
      mon(1, b.rtc_as, b.rtc_wr_n, b.rtc_cs_n, b.busy, b.done, b.err, b.rtc_rd_n, b.rtc_ad_out);
   end
   task automatic wait_idle(input int i);
      int c = 0;
      while ((i == 0 ? a.busy : b.busy) && c < 500) begin
         @(negedge clk);
         c++;
      end
      if (c == 500) fail("busy_timeout");
      @(negedge clk);
   endtask
   task automatic push_time(input int i, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      expq[i].push_back({8'h21, s});
      expq[i].push_back({8'h22, m});
      expq[i].push_back({8'h23, h});
`ifdef RTC_XFER_CMD_EN
      expq[i].push_back({8'hF0, 8'hF2});
`endif
   endtask
   task automatic start_a(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      a.hour_bcd = h;
      a.min_bcd  = m;
      a.sec_bcd  = s;
      a.start    = 1'b1;
      @(negedge clk);
      a.start = 1'b0;
   endtask
   logic [7:0] inv_h[4] = '{8'h13, 8'h00, 8'h07, 8'h07};
   logic [7:0] inv_m[4] = '{8'h45, 8'h45, 8'h60, 8'h45};
   logic [7:0] inv_s[4] = '{8'h30, 8'h30, 8'h30, 8'h3A};
   initial begin
      int c;
      reset = 1'b1;
      a.start = 1'b0; a.hour_bcd = 8'h0; a.min_bcd = 8'h0; a.sec_bcd = 8'h0;
      b.start = 1'b0; b.hour_bcd = 8'h0; b.min_bcd = 8'h0; b.sec_bcd = 8'h0;
      repeat (3) @(negedge clk);
      chk("reset_a", {a.busy, a.done, a.err, a.rtc_cs_n, a.rtc_as, a.rtc_wr_n, a.rtc_rd_n, a.rtc_ad_oe, a.rtc_ad_out}, RSTV);
      chk("reset_b", {b.busy, b.done, b.err, b.rtc_cs_n, b.rtc_as, b.rtc_wr_n, b.rtc_rd_n, b.rtc_ad_oe, b.rtc_ad_out}, RSTV);
      reset = 1'b0;
      // basic write straight out of reset
      push_time(0, 8'h07, 8'h45, 8'h30);
      lenq[0].push_back(NW * 20);
      start_a(8'h07, 8'h45, 8'h30);
      chk("lat_k", {31'h0, a.busy}, 0);
      @(negedge clk);
      chk("lat_k1", {31'h0, a.busy}, 1);
      chk("lat_k1_bus", {a.rtc_cs_n, a.rtc_as, a.rtc_ad_oe, a.rtc_ad_out}, {3'b011, 8'h21});
      wait_idle(0);
      // invalid BCD snapshots
      for (int k = 0; k < 4; k++) begin
         errq.push_back(k);
         start_a(inv_h[k], inv_m[k], inv_s[k]);
         repeat (2) @(negedge clk);
         chk("err_seen", errq.size(), 0);
         chk("err_one_cycle", {31'h0, a.err}, 0);
         chk("inv_no_bus", {a.busy, a.rtc_cs_n, a.rtc_ad_oe}, 3'b010);
      end
      // restart and input changes mid-sequence are ignored
      push_time(0, 8'h11, 8'h59, 8'h01);
      lenq[0].push_back(NW * 20);
      start_a(8'h11, 8'h59, 8'h01);
      repeat (9) @(negedge clk);
      start_a(8'h05, 8'h12, 8'h34);
      wait_idle(0);
      chk("restart_q_empty", expq[0].size() + lenq[0].size(), 0);
      // reset in the DATA phase of the minutes write
      expq[0].push_back({8'h21, 8'h22});
      expq[0].push_back({8'h22, 8'h33});
      start_a(8'h09, 8'h33, 8'h22);
      c = 0;
      while (!(!a.rtc_wr_n && a.rtc_ad_out == 8'h33) && c < 200) begin
         @(negedge clk);
         c++;
      end
      if (c == 200) fail("min_data_timeout");
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_mid", {a.rtc_cs_n, a.rtc_wr_n, a.rtc_ad_oe, a.busy}, 4'b1100);
      chk("rst_mid_all", {a.busy, a.done, a.err, a.rtc_cs_n, a.rtc_as, a.rtc_wr_n, a.rtc_rd_n, a.rtc_ad_oe, a.rtc_ad_out}, RSTV);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      chk("rst_q_empty", expq[0].size(), 0);
      // single-cycle phases
      push_time(1, 8'h12, 8'h00, 8'h00);
      lenq[1].push_back(NW * 5);
      b.hour_bcd = 8'h12; b.min_bcd = 8'h00; b.sec_bcd = 8'h00; b.start = 1'b1;
      @(negedge clk);
      b.start = 1'b0;
      @(negedge clk);
      wait_idle(1);
      chk("fast_q_empty", expq[1].size() + lenq[1].size(), 0);
      chk("rd_n_high", {31'h0, rd_bad}, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
